memory_bus_arbiter: RTL

Round-robin arbiter for the coprocessor's single shared memory port, with a bounded hold time per owner. Requesters are the main control unit (index 0) and the P processing elements (indexes 1..P). Exactly one owner drives the shared memory data/address lines at a time, and a turnaround cycle is inserted between owners so the bidirectional data bus is never contended. The block also enforces a hold timeout so a hung requester cannot starve the others.

---
 rtl/memory_bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memory_bus_arbiter.sv
// Round-robin owner arbiter for the shared memory port. A bounded hold time
// and a one-cycle turnaround between owners keep the bidirectional bus uncontended.
module memory_bus_arbiter #(
  parameter int unsigned P        = 4,
  parameter int unsigned MAX_HOLD = 64,
  parameter int unsigned HOLD_W   = 8,
  localparam int unsigned N       = P + 1,
  localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_Clock,
  input  logic             i_Reset_n,
  input  logic [N-1:0]     i_Request,
  output logic [N-1:0]     o_Grant,
  output logic [IDX_W-1:0] o_Grant_Index,
  output logic             o_Busy,
  output logic             o_Timeout
);

  typedef enum logic [1:0] {
    s_idle,
    s_granted,
    s_turnaround
  } state_t;

  localparam bit               HOLD_EN    = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
  localparam logic [IDX_W-1:0]  LAST_INIT = IDX_W'(P);

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   winner;

  // First set request scanning upward from the slot after the previous owner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             hit;
    pick = last;
    hit  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (last >= IDX_W'(N - k)) ? (last - IDX_W'(N - k)) : (last + IDX_W'(k));
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(i_Request, last_q);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= s_idle;
      grant_q   <= '0;
      index_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
      last_q    <= LAST_INIT;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      index_q   <= index_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    index_d   = index_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    last_d    = last_q;

    case (state_q)
      s_idle: begin
        if (|i_Request) begin
          state_d = s_granted;
          grant_d = N'(1) << winner;
          index_d = winner;
          busy_d  = 1'b1;
          hold_d  = '0;
          last_d  = winner;
        end
      end

      s_granted: begin
        // A release takes precedence over a timeout landing on the same cycle.
        if (!i_Request[index_q]) begin
          state_d = s_turnaround;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (HOLD_EN && (hold_q == HOLD_LAST)) begin
          state_d   = s_turnaround;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      s_turnaround: begin
        state_d = s_idle;
      end

      default: begin
        state_d = s_idle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_Grant       = grant_q;
  assign o_Grant_Index = index_q;
  assign o_Busy        = busy_q;
  assign o_Timeout     = timeout_q;

  // Structural invariants of the registered grant outputs.
  a_grant_onehot0: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    $onehot0(grant_q));
  a_busy_matches: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    busy_q == (|grant_q));
  a_index_matches: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    busy_q |-> grant_q[index_q]);
  a_timeout_idle: assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    timeout_q |-> !busy_q);

endmodule
